// File: rtl/bsg_cache_non_blocking_resp_reorder_pkg.sv
// Shared helpers for the non-blocking cache response reorder buffer.
package bsg_cache_non_blocking_resp_reorder_pkg;

  // Ceiling log2 that never returns less than 1, so a slot index always has a bit.
  function automatic int unsigned safe_clog2(input int unsigned n);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd31; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return (r < 32'd1) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/bsg_cache_non_blocking_resp_reorder_chk.sv
// Simulation-only protocol checks for the reorder buffer's requester and cache interfaces.
module bsg_cache_non_blocking_resp_reorder_chk #(
  parameter int unsigned els_p        = 8,
  parameter int unsigned id_width_p   = 30,
  parameter int unsigned lg_els_p     = 3,
  parameter int unsigned ptr_width_p  = 4
) (
  input logic                   clk_i,
  input logic                   reset_i,
  input logic                   alloc_v_i,
  input logic                   alloc_ready_i,
  input logic                   resp_v_i,
  input logic [id_width_p-1:0]  resp_id_i,
  input logic                   v_i,
  input logic                   yumi_i,
  input logic [els_p-1:0]       filled_i,
  input logic [lg_els_p-1:0]    rd_slot_i,
  input logic [ptr_width_p-1:0] count_i
);

  logic [lg_els_p-1:0] resp_slot_s;
  logic [lg_els_p-1:0] resp_off_s;
  logic                resp_allocated_s;

  assign resp_slot_s      = resp_id_i[lg_els_p-1:0];
  assign resp_off_s       = resp_slot_s - rd_slot_i;
  assign resp_allocated_s = ({1'b0, resp_off_s} < count_i);

  // Flag illegal handshakes at each edge while out of reset.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(alloc_v_i && !alloc_ready_i))
        else $error("alloc_v_i asserted while alloc_ready_o low");
      assert (!(yumi_i && !v_i))
        else $error("yumi_i asserted without v_o");
      assert (!(resp_v_i && ((resp_id_i >> lg_els_p) != '0)))
        else $error("resp_id_i upper bits nonzero");
      assert (!(resp_v_i && !resp_allocated_s))
        else $error("response to unallocated slot");
      assert (!(resp_v_i && filled_i[resp_slot_s]))
        else $error("response to already filled slot");
    end
  end

endmodule

// File: rtl/bsg_cache_non_blocking_resp_reorder_mem.sv
// Register-file storage: one synchronous write port and one asynchronous read port.
module bsg_mem_1r1w
  import bsg_cache_non_blocking_resp_reorder_pkg::*;
#(
  parameter int unsigned width_p       = 32,
  parameter int unsigned els_p         = 8,
  parameter int unsigned addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // Data is deliberately not reset; slot validity is tracked by the owner.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_cache_non_blocking_resp_reorder.sv
// Allocates cache request ids, absorbs out-of-order responses and re-emits their data
// in allocation order.
module bsg_cache_non_blocking_resp_reorder
  import bsg_cache_non_blocking_resp_reorder_pkg::*;
#(
  parameter int unsigned els_p        = 8,
  parameter int unsigned id_width_p   = 30,
  parameter int unsigned data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    alloc_v_i,
  output logic                    alloc_ready_o,
  output logic [id_width_p-1:0]   alloc_id_o,

  input  logic                    resp_v_i,
  input  logic [id_width_p-1:0]   resp_id_i,
  input  logic [data_width_p-1:0] resp_data_i,
  output logic                    resp_yumi_o,

  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  input  logic                    yumi_i
);

  localparam int unsigned lg_els_lp    = safe_clog2(els_p);
  localparam int unsigned ptr_width_lp = lg_els_lp + 32'd1;

  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r, count_s;
  logic [els_p-1:0]        filled_r, filled_n_s;
  logic [lg_els_lp-1:0]    wr_slot_s, rd_slot_s, resp_slot_s;
  logic                    full_s, empty_s, alloc_s, deq_s, accept_s;

  assign wr_slot_s   = wr_ptr_r[lg_els_lp-1:0];
  assign rd_slot_s   = rd_ptr_r[lg_els_lp-1:0];
  assign resp_slot_s = resp_id_i[lg_els_lp-1:0];

  // The extra pointer MSB distinguishes full from empty when the slot bits match.
  assign count_s = wr_ptr_r - rd_ptr_r;
  assign full_s  = (count_s == ptr_width_lp'(els_p));
  assign empty_s = (count_s == '0);

  // Ready depends only on registered state, never on this cycle's yumi_i.
  assign alloc_ready_o = ~reset_i & ~full_s;
  assign alloc_id_o    = id_width_p'(wr_slot_s);
  assign resp_yumi_o   = ~reset_i & resp_v_i;
  assign v_o           = ~reset_i & ~empty_s & filled_r[rd_slot_s];

  assign alloc_s  = alloc_v_i & alloc_ready_o;
  assign deq_s    = v_o & yumi_i;
  assign accept_s = resp_yumi_o;

  // Next-state filled bits: a response never targets the slot being dequeued.
  always_comb begin
    filled_n_s = filled_r;
    if (accept_s) begin
      filled_n_s[resp_slot_s] = 1'b1;
    end else begin
      filled_n_s[resp_slot_s] = filled_r[resp_slot_s];
    end
    if (deq_s) begin
      filled_n_s[rd_slot_s] = 1'b0;
    end else begin
      filled_n_s[rd_slot_s] = filled_n_s[rd_slot_s];
    end
  end

  // Pointer and filled-bit state with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      filled_r <= '0;
    end else begin
      wr_ptr_r <= alloc_s ? (wr_ptr_r + ptr_width_lp'(1)) : wr_ptr_r;
      rd_ptr_r <= deq_s   ? (rd_ptr_r + ptr_width_lp'(1)) : rd_ptr_r;
      filled_r <= filled_n_s;
    end
  end

  bsg_mem_1r1w #(
    .width_p (data_width_p),
    .els_p   (els_p)
  ) data_mem (
    .w_clk_i  (clk_i),
    .w_v_i    (accept_s),
    .w_addr_i (resp_slot_s),
    .w_data_i (resp_data_i),
    .r_addr_i (rd_slot_s),
    .r_data_o (data_o)
  );

  bsg_cache_non_blocking_resp_reorder_chk #(
    .els_p       (els_p),
    .id_width_p  (id_width_p),
    .lg_els_p    (lg_els_lp),
    .ptr_width_p (ptr_width_lp)
  ) chk (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .alloc_v_i     (alloc_v_i),
    .alloc_ready_i (alloc_ready_o),
    .resp_v_i      (resp_v_i),
    .resp_id_i     (resp_id_i),
    .v_i           (v_o),
    .yumi_i        (yumi_i),
    .filled_i      (filled_r),
    .rd_slot_i     (rd_slot_s),
    .count_i       (count_s)
  );

endmodule
